nab_axi_lite_regs: RTL
======================

// Module: nab_axi_lite_regs
// PURPOSE
//  AXI4-Lite responder (slave) for the neuromorphic ASIC bridge: decodes host reads/writes into an 8-word register bank.
//  Exposes control/LED registers to the fabric and returns the live network-output status word to the host.
//  Sits between the PS/host AXI interconnect and the bridge datapath (spike PWM, XADC front end, LED drive).
// PARAMETERS
//  C_S_AXI_ADDR_WIDTH  9    byte address width
//  C_S_AXI_DATA_WIDTH  32   data width; only 32 supported
//  NUM_REGS            8    word registers at 0x00..0x1C
// PORTS
//  S_AXI_ACLK     in   1   single clock for all logic
//  S_AXI_ARESET   in   1   synchronous, active-high reset
//  S_AXI_AWADDR   in   9   write address;  S_AXI_AWVALID in 1;  S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   32  write data;  S_AXI_WSTRB in 4;  S_AXI_WVALID in 1;  S_AXI_WREADY out 1
//  S_AXI_BRESP    out  2   write response;  S_AXI_BVALID out 1;  S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   9   read address;  S_AXI_ARVALID in 1;  S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  32  read data;  S_AXI_RRESP out 2;  S_AXI_RVALID out 1;  S_AXI_RREADY in 1
//  net_status     in   32  network output word from datapath (same clock domain)
//  ctrl_reg       out  32  register 0x00 contents
//  leds           out  8   register 0x08 bits [7:0]
// BEHAVIOUR
//  Reset: all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, all RW registers 0, ctrl_reg=0, leds=0.
//  Map: 0x00 CTRL RW | 0x04 STATUS RO (=net_status) | 0x08 LED RW | 0x0C..0x1C SCRATCH RW. ADDR[1:0] ignored.
//  Write FSM W_IDLE->W_ACK->W_RESP:
//   W_IDLE: AWVALID&&WVALID both sampled high -> AWREADY=WREADY=1 next cycle (W_ACK). Never accepts on only one valid.
//   W_ACK: exactly one-cycle READY pulse; register updated at end of this cycle; -> W_RESP with BVALID=1.
//   W_RESP: BVALID held until BREADY sampled high; then -> W_IDLE. No new write accepted while BVALID=1.
//   Master holding AW/W valid one cycle past the READY pulse must not cause a second write.
//  Read FSM R_IDLE->R_ACK->R_DATA:
//   R_IDLE: ARVALID -> ARREADY=1 one cycle (R_ACK); RDATA/RRESP latched at that edge; -> R_DATA with RVALID=1.
//   R_DATA: RDATA stable, RVALID held until RREADY; then R_IDLE. Read latency ARVALID->RVALID = 2 cycles.
//  STATUS read returns net_status sampled at the R_ACK edge. Writes to 0x04 ignored, BRESP=OKAY.
//  Address >= 0x20 (NUM_REGS*4): write discarded, BRESP=SLVERR(2'b10); read RDATA=0, RRESP=SLVERR. Else OKAY.
//  Read and write channels independent; simultaneous read/write of same register: read returns pre-write value.
//  Reset asserted mid-transaction: both FSMs to IDLE next edge, pending BVALID/RVALID dropped, registers cleared.
// CONFIGURATION
//  NAB_REG_WSTRB_EN defined: byte lane i written only if WSTRB[i]=1; WSTRB=4'h0 writes nothing but still BRESP=OKAY.
//  Undefined: WSTRB ignored, every accepted write updates the full 32-bit word.
// STRUCTURE
//  Package nab_regs_pkg: register offsets (CTRL/STATUS/LED/SCRATCH0..4), NUM_REGS, RESP_OKAY/RESP_SLVERR, FSM state encodings.
//  One sub-module nab_reg_bank: word storage, strobe merge (macro-dependent), RO mux for STATUS; FSMs stay in top.
// TESTING
//  1 Reset, then write 0xDEADBEEF to 0x00..0x1C with WSTRB=4'hF -> each READY one-cycle pulse, BRESP=00; ctrl_reg=DEADBEEF, leds=EF.
//  2 Read 0x00..0x1C, net_status=0x0000_0005 -> RDATA DEADBEEF except 0x04=00000005; RVALID 2 cycles after ARVALID, held until RREADY.
//  3 Valids held 1 cycle past READY, BREADY low 5 cycles -> exactly one write, BVALID stays high 5 cycles, no second accept.
//  4 Write/read 0x40 -> BRESP=10, RRESP=10, RDATA=0; bank unchanged.
//  5 WSTRB=4'b0011 write 0x12345678 to 0x0C after DEADBEEF: with NAB_REG_WSTRB_EN ->DEAD5678; without ->12345678.
//  6 Assert S_AXI_ARESET while BVALID and RVALID high -> both 0 next cycle, all registers 0, next write completes normally.

Source files
------------

// File: rtl/nab_regs_pkg.sv
// nab_regs_pkg: register map, response codes and FSM encodings shared by the AXI-Lite register block
package nab_regs_pkg;
    localparam int C_S_AXI_ADDR_WIDTH = 9;
    localparam int C_S_AXI_DATA_WIDTH = 32;
    localparam int NUM_REGS = 8;
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_CTRL     = 9'h000;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_STATUS   = 9'h004;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_LED      = 9'h008;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_SCRATCH0 = 9'h00C;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_SCRATCH1 = 9'h010;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_SCRATCH2 = 9'h014;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_SCRATCH3 = 9'h018;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_SCRATCH4 = 9'h01C;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;
    function automatic logic in_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
        return addr < C_S_AXI_ADDR_WIDTH'(NUM_REGS * 4);
    endfunction
    function automatic logic [IDX_W-1:0] word_idx(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction
endpackage

// File: rtl/nab_axi_lite_regs_if.sv
// nab_axi_lite_regs_if: AXI4-Lite bus bundle between host interconnect and the register block
interface nab_axi_lite_regs_if;
    import nab_regs_pkg::*;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
    logic                          awvalid;
    logic                          awready;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata;
    logic [3:0]                    wstrb;
    logic                          wvalid;
    logic                          wready;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
    logic                          arvalid;
    logic                          arready;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                    rresp;
    logic                          rvalid;
    logic                          rready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/nab_reg_bank.sv
// nab_reg_bank: 8-word register storage with byte-strobe merge (NAB_REG_WSTRB_EN) and live STATUS word
module nab_reg_bank
    import nab_regs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic [IDX_W-1:0]  ridx,
    input  logic [31:0]       net_status,
    output logic [31:0]       rdata,
    output logic [31:0]       ctrl_reg,
    output logic [7:0]        leds
);
    logic [31:0] regs [NUM_REGS];
    logic [31:0] merged;
`ifdef NAB_REG_WSTRB_EN
    // only lanes with their strobe set take new data; the rest keep the stored bytes
    always_comb begin
        merged = regs[widx];
        for (int i = 0; i < 4; i++) merged[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : merged[8*i +: 8];
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
    assign merged = wdata;
`endif
    // word storage; the STATUS slot is read-only so writes to it are dropped
    always_ff @(posedge clk) begin
        if (rst) regs <= '{default: '0};
        else if (we && widx != word_idx(ADDR_STATUS)) regs[widx] <= merged;
    end
    assign rdata    = (ridx == word_idx(ADDR_STATUS)) ? net_status : regs[ridx];
    assign ctrl_reg = regs[word_idx(ADDR_CTRL)];
    assign leds     = regs[word_idx(ADDR_LED)][7:0];
endmodule

// File: rtl/nab_axi_lite_regs.sv
// nab_axi_lite_regs: AXI4-Lite responder decoding host accesses into an 8-word register bank (option: NAB_REG_WSTRB_EN)
module nab_axi_lite_regs
    import nab_regs_pkg::*;
(
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    nab_axi_lite_regs_if.slave    s_axi,
    input  logic [31:0]           net_status,
    output logic [31:0]           ctrl_reg,
    output logic [7:0]            leds
);
    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q, bank_rdata;
    logic        we;

    assign we = (w_state == W_ACK) && in_range(s_axi.awaddr);

    nab_reg_bank bank (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .we(we),
        .widx(word_idx(s_axi.awaddr)), .wdata(s_axi.wdata), .wstrb(s_axi.wstrb),
        .ridx(word_idx(s_axi.araddr)), .net_status(net_status), .rdata(bank_rdata),
        .ctrl_reg(ctrl_reg), .leds(leds)
    );

    // write FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) w_state <= W_IDLE;
        else w_state <= w_next;
    end

    // write FSM: accept only with both AW and W valid, pulse READY once, then hold the response until taken
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  w_next = (s_axi.awvalid && s_axi.wvalid) ? W_ACK : W_IDLE;
            W_ACK:   w_next = W_RESP;
            W_RESP:  w_next = s_axi.bready ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
    end

    // write response code captured alongside the register update
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) bresp_q <= RESP_OKAY;
        else if (w_state == W_ACK) bresp_q <= in_range(s_axi.awaddr) ? RESP_OKAY : RESP_SLVERR;
    end

    // read FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_state <= R_IDLE;
        else r_state <= r_next;
    end

    // read FSM: one-cycle ARREADY, then hold the latched data until the host takes it
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  r_next = s_axi.arvalid ? R_ACK : R_IDLE;
            R_ACK:   r_next = R_DATA;
            R_DATA:  r_next = s_axi.rready ? R_IDLE : R_DATA;
            default: r_next = R_IDLE;
        endcase
    end

    // read data latched at the end of the ARREADY cycle so a same-cycle write is not seen
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (r_state == R_ACK) begin
            rdata_q <= in_range(s_axi.araddr) ? bank_rdata : '0;
            rresp_q <= in_range(s_axi.araddr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi.awready = (w_state == W_ACK);
    assign s_axi.wready  = (w_state == W_ACK);
    assign s_axi.bvalid  = (w_state == W_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = (r_state == R_ACK);
    assign s_axi.rvalid  = (r_state == R_DATA);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
endmodule
